// File: rtl/eth_tx_payload_mux.sv
// Arbitrates fmt/img UDP payloads onto one UDP tx core; fmt wins ties, img gated by fmt_busy. Optional stats via TX_MUX_STATS_EN.
// Latency: start pulse N -> udp_tx_start N+2; udp_tx_done M -> *_tx_done M+1, next start >= M+IFG_CYC+2.
// Backpressure: bytes move only on udp_tx_req; extra starts while pending merge and set drop_err.
module eth_tx_payload_mux #(
    parameter logic [15:0] IFG_CYC     = 16'd12,
    parameter logic [27:0] TIMEOUT_CYC = 28'd25_000_000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        fmt_start,
    input  logic [7:0]  fmt_data,
    input  logic [15:0] fmt_num,
    input  logic        fmt_busy,
    input  logic        img_start,
    input  logic [7:0]  img_data,
    input  logic [15:0] img_num,
    input  logic        udp_tx_req,
    input  logic        udp_tx_done,
    output logic        udp_tx_start,
    output logic [7:0]  udp_tx_data,
    output logic [15:0] udp_tx_byte_num,
    output logic        fmt_req,
    output logic        img_req,
    output logic        fmt_tx_done,
    output logic        img_tx_done,
`ifdef TX_MUX_STATS_EN
    output logic [15:0] stat_fmt_pkts,
    output logic [15:0] stat_img_pkts,
`endif
    output logic        drop_err,
    output logic        timeout_err
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_SEND  = 2'd2,
        S_GAP   = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic        owner_img_q;
    logic        fmt_pend_q, img_pend_q;
    logic [27:0] wd_cnt_q;
    logic [15:0] gap_cnt_q;
    logic        grant_fmt, grant_img;
    logic        send_done, wd_expire;
    logic        in_send;

    always_comb begin
        state_d   = state_q;
        grant_fmt = 1'b0;
        grant_img = 1'b0;
        send_done = 1'b0;
        wd_expire = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (fmt_pend_q) begin
                    grant_fmt = 1'b1;
                    state_d   = S_START;
                end else if (img_pend_q && !fmt_busy) begin
                    grant_img = 1'b1;
                    state_d   = S_START;
                end
            end
            S_START: state_d = S_SEND;
            S_SEND: begin
                // done beats a watchdog expiry landing in the same cycle
                if (udp_tx_done) begin
                    send_done = 1'b1;
                    state_d   = (IFG_CYC == 16'd0) ? S_IDLE : S_GAP;
                end else if (({1'b0, wd_cnt_q} + 29'd1) >= {1'b0, TIMEOUT_CYC}) begin
                    wd_expire = 1'b1;
                    state_d   = S_IDLE;
                end
            end
            S_GAP: begin
                if (({1'b0, gap_cnt_q} + 17'd1) >= {1'b0, IFG_CYC})
                    state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign in_send      = (state_q == S_SEND);
    assign udp_tx_start = (state_q == S_START);
    assign fmt_req      = in_send && udp_tx_req && !owner_img_q;
    assign img_req      = in_send && udp_tx_req && owner_img_q;

    always_comb begin
        udp_tx_data = 8'd0;
        if (in_send)
            udp_tx_data = owner_img_q ? img_data : fmt_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q         <= S_IDLE;
            owner_img_q     <= 1'b0;
            fmt_pend_q      <= 1'b0;
            img_pend_q      <= 1'b0;
            udp_tx_byte_num <= 16'd0;
            wd_cnt_q        <= 28'd0;
            gap_cnt_q       <= 16'd0;
            fmt_tx_done     <= 1'b0;
            img_tx_done     <= 1'b0;
            drop_err        <= 1'b0;
            timeout_err     <= 1'b0;
        end else begin
            state_q <= state_d;
            // a start landing on its own grant cycle is a fresh packet, not a drop
            fmt_pend_q <= fmt_start || (fmt_pend_q && !grant_fmt);
            img_pend_q <= img_start || (img_pend_q && !grant_img);
            if ((fmt_start && fmt_pend_q && !grant_fmt) ||
                (img_start && img_pend_q && !grant_img))
                drop_err <= 1'b1;
            if (wd_expire)
                timeout_err <= 1'b1;
            if (grant_fmt) begin
                owner_img_q     <= 1'b0;
                udp_tx_byte_num <= fmt_num;
            end else if (grant_img) begin
                owner_img_q     <= 1'b1;
                udp_tx_byte_num <= img_num;
            end
            if (state_d != state_q) begin
                wd_cnt_q  <= 28'd0;
                gap_cnt_q <= 16'd0;
            end else begin
                if (in_send)
                    wd_cnt_q <= wd_cnt_q + 28'd1;
                if (state_q == S_GAP)
                    gap_cnt_q <= gap_cnt_q + 16'd1;
            end
            fmt_tx_done <= send_done && !owner_img_q;
            img_tx_done <= send_done && owner_img_q;
        end
    end

`ifdef TX_MUX_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_fmt_pkts <= 16'd0;
            stat_img_pkts <= 16'd0;
        end else begin
            if (fmt_tx_done)
                stat_fmt_pkts <= stat_fmt_pkts + 16'd1;
            if (img_tx_done)
                stat_img_pkts <= stat_img_pkts + 16'd1;
        end
    end
`endif

endmodule
